pulse_train_tx: RTL and testbench
=================================

PULSE_TRAIN_TX -- requirements
Module: pulse_train_tx

Interface
REQ-001 SHALL have parameter CW, default 8: width of the count and length fields.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port START, input, 1: request a pulse train; sampled only in IDLE.
REQ-005 SHALL have port NPULSE, input, CW: number of pulses in the train.
REQ-006 SHALL have port HIGH_CYC, input, CW: high-phase length in clock cycles.
REQ-007 SHALL have port LOW_CYC, input, CW: low-phase length in clock cycles.
REQ-008 SHALL have port DOUT, output, 1: registered pulse output, glitch-free.
REQ-009 SHALL have port BUSY, output, 1: high while a train is in progress.
REQ-010 SHALL have port DONE, output, 1: one-cycle completion strobe.
REQ-011 SHALL have port PCOUNT, output, CW: number of pulses completed in the current or last train.

Function
REQ-012 SHALL implement the states IDLE, HIGH, LOW and FIN.
- Every output SHALL be a direct register or a state decode; no input-to-output combinational path.
REQ-013 In IDLE with START=1 at edge k, the block SHALL:
- latch NPULSE, HIGH_CYC and LOW_CYC;
- clear PCOUNT;
- enter HIGH, or enter FIN if NPULSE=0.
REQ-014 Once a train is accepted, changes to the config inputs SHALL have no effect until the next accepted START.
REQ-015 In HIGH, DOUT SHALL be 1 for exactly max(HIGH_CYC,1) cycles, starting the cycle after edge k.
REQ-016 On leaving HIGH, PCOUNT SHALL increment by 1.
- If PCOUNT then equals the latched NPULSE, the next state SHALL be FIN.
- Otherwise the next state SHALL be LOW, or HIGH directly if LOW_CYC=0.
REQ-017 In LOW, DOUT SHALL be 0 for exactly LOW_CYC cycles, then the state SHALL return to HIGH.
REQ-018 FIN SHALL last exactly one cycle, with DONE=1, BUSY=0 and DOUT=0; the state SHALL then return to IDLE.
REQ-019 BUSY SHALL be 1 in HIGH and LOW only.
REQ-020 DONE SHALL be 1 in FIN only.
REQ-021 START asserted in HIGH, LOW or FIN SHALL be ignored: not queued and not latched.
REQ-022 START held high continuously SHALL start a new train on the first IDLE cycle after FIN; trains SHALL be separated by at least one IDLE cycle.
REQ-023 Phase counters SHALL be CW bits wide, count down, and never wrap.
- Maximum phase length SHALL be 2^CW-1 cycles.
- NPULSE=2^CW-1 SHALL produce exactly that many pulses.
REQ-024 PCOUNT SHALL hold its final value after FIN until the next accepted START.

Reset
REQ-025 RST=1 SHALL immediately, without waiting for a CLK edge, force:
- state to IDLE;
- DOUT, BUSY and DONE to 0;
- PCOUNT and all internal counters to 0.
REQ-026 RST asserted mid-train SHALL abort the train with no DONE strobe; the first START after RST deasserts SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold:
- the state enumeration type (IDLE, HIGH, LOW, FIN);
- the default CW constant.
REQ-028 One sub-module, pt_down_counter (load, decrement, zero flag, CW wide), SHALL be instantiated for phase timing; the FSM and pulse counting SHALL remain in pulse_train_tx.

Verification
REQ-029 NPULSE=2, HIGH_CYC=3, LOW_CYC=2, START pulse -> DOUT pattern 1,1,1,0,0,1,1,1, then DONE=1 for one cycle; PCOUNT=2; BUSY high for 8 cycles.
REQ-030 NPULSE=0, START -> no DOUT pulse; DONE=1 on the cycle after acceptance; PCOUNT=0.
REQ-031 NPULSE=3, HIGH_CYC=0, LOW_CYC=0 -> DOUT held high for 3 consecutive cycles (1-cycle pulses, no low gap); PCOUNT=3; DONE once.
REQ-032 NPULSE=4, HIGH_CYC=5, LOW_CYC=5:
- START re-pulsed and config changed during the train -> train unaffected;
- exactly 4 pulses; a single DONE.
REQ-033 RST asserted mid-phase, between clock edges, during the second HIGH phase of NPULSE=5 -> DOUT, BUSY and PCOUNT are 0 immediately; no DONE; a later START with NPULSE=1 yields exactly one pulse.
REQ-034 START held high for 40 cycles with NPULSE=1, HIGH_CYC=2, LOW_CYC=1 -> repeated trains, each 2 high cycles, then DONE, then 1 IDLE cycle.

Source files
------------

// File: rtl/pulse_train_tx_pkg.sv
// pulse_train_tx_pkg: shared state type and default field width for the pulse train transmitter
package pulse_train_tx_pkg;
    localparam int CW_DEFAULT = 8;
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} pt_state_e;
endpackage

// File: rtl/pt_down_counter.sv
// pt_down_counter: loadable phase down-counter that saturates at zero
module pt_down_counter
    import pulse_train_tx_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/pulse_train_tx.sv
// pulse_train_tx: emits NPULSE pulses of HIGH_CYC high / LOW_CYC low cycles per accepted START
module pulse_train_tx
    import pulse_train_tx_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [CW-1:0] NPULSE,
    input  logic [CW-1:0] HIGH_CYC,
    input  logic [CW-1:0] LOW_CYC,
    output logic          DOUT,
    output logic          BUSY,
    output logic          DONE,
    output logic [CW-1:0] PCOUNT
);
    pt_state_e     state_q, state_d;
    logic [CW-1:0] npulse_q, npulse_d, high_q, high_d, low_q, low_d, pcount_q, pcount_d;
    logic          dout_q, dout_d, busy_q, busy_d, done_q, done_d;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_val;

    // counter holds remaining cycles minus one, so a zero-length high phase still lasts one cycle
    function automatic logic [CW-1:0] phase_load(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    pt_down_counter #(.CW(CW)) u_phase (
        .clk     (CLK),
        .rst     (RST),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(cnt_val),
        .zero    (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q  <= IDLE;
            npulse_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            pcount_q <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            npulse_q <= npulse_d;
            high_q   <= high_d;
            low_q    <= low_d;
            pcount_q <= pcount_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end

    always_comb begin
        state_d  = state_q;
        npulse_d = npulse_q;
        high_d   = high_q;
        low_d    = low_q;
        pcount_d = pcount_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: if (START) begin
                npulse_d = NPULSE;
                high_d   = HIGH_CYC;
                low_d    = LOW_CYC;
                pcount_d = '0;
                state_d  = (NPULSE == '0) ? FIN : HIGH;
                cnt_load = NPULSE != '0;
                cnt_val  = phase_load(HIGH_CYC);
            end
            HIGH: if (cnt_zero) begin
                pcount_d = pcount_q + 1'b1;
                state_d  = (pcount_d == npulse_q) ? FIN : (low_q == '0) ? HIGH : LOW;
                cnt_load = pcount_d != npulse_q;
                cnt_val  = (low_q == '0) ? phase_load(high_q) : low_q - 1'b1;
            end else cnt_dec = 1'b1;
            LOW: if (cnt_zero) begin
                state_d  = HIGH;
                cnt_load = 1'b1;
                cnt_val  = phase_load(high_q);
            end else cnt_dec = 1'b1;
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from the next state so they stay glitch-free state decodes
    always_comb begin
        dout_d = state_d == HIGH;
        busy_d = state_d == HIGH || state_d == LOW;
        done_d = state_d == FIN;
    end

    assign DOUT   = dout_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign PCOUNT = pcount_q;
endmodule

// File: tb/tb_pulse_train_tx.sv
// tb_pulse_train_tx: checks pulse_train_tx cycle by cycle against an expected-waveform queue
module tb_pulse_train_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic [7:0] NPULSE = '0, HIGH_CYC = '0, LOW_CYC = '0;
    logic       DOUT, BUSY, DONE;
    logic [7:0] PCOUNT;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] busy;
        logic [7:0] done;
        logic [7:0] pc;
    } exp_t;
    exp_t exp_q[$];

    pulse_train_tx dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .NPULSE  (NPULSE),
        .HIGH_CYC(HIGH_CYC),
        .LOW_CYC (LOW_CYC),
        .DOUT    (DOUT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .PCOUNT  (PCOUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // expected per-cycle waveform after acceptance: pulses, gaps, then one FIN cycle
    function automatic void build(input int n, input int h, input int l);
        int pc = 0;
        int hh = (h == 0) ? 1 : h;
        exp_q.delete();
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < hh; c++) exp_q.push_back('{8'd1, 8'd1, 8'd0, 8'(pc)});
            pc++;
            if (p != n - 1)
                for (int c = 0; c < l; c++) exp_q.push_back('{8'd0, 8'd1, 8'd0, 8'(pc)});
        end
        exp_q.push_back('{8'd0, 8'd0, 8'd1, 8'(n)});
    endfunction

    task automatic run_train(input int n, input int h, input int l, input bit disturb, input bit hold, input string tag);
        build(n, h, l);
        START = 1'b1;
        NPULSE = 8'(n);
        HIGH_CYC = 8'(h);
        LOW_CYC = 8'(l);
        @(posedge CLK);
        foreach (exp_q[i]) begin
            @(negedge CLK);
            chk({tag, ".dout"}, {7'd0, DOUT}, exp_q[i].dout);
            chk({tag, ".busy"}, {7'd0, BUSY}, exp_q[i].busy);
            chk({tag, ".done"}, {7'd0, DONE}, exp_q[i].done);
            chk({tag, ".pcount"}, PCOUNT, exp_q[i].pc);
            if (disturb) begin
                START = 1'($urandom_range(0, 1));
                NPULSE = 8'($urandom);
                HIGH_CYC = 8'($urandom);
                LOW_CYC = 8'($urandom);
            end else if (!hold) START = 1'b0;
        end
        @(negedge CLK);
        chk({tag, ".idle_dout"}, {7'd0, DOUT}, 8'd0);
        chk({tag, ".idle_busy"}, {7'd0, BUSY}, 8'd0);
        chk({tag, ".idle_done"}, {7'd0, DONE}, 8'd0);
        chk({tag, ".idle_pcount"}, PCOUNT, 8'(n));
        if (!hold) START = 1'b0;
    endtask

    initial begin
        #1 RST = 1'b1;
        #1;
        chk("rst.dout", {7'd0, DOUT}, 8'd0);
        chk("rst.busy", {7'd0, BUSY}, 8'd0);
        chk("rst.done", {7'd0, DONE}, 8'd0);
        chk("rst.pcount", PCOUNT, 8'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        run_train(2, 3, 2, 1'b0, 1'b0, "basic");
        run_train(0, 4, 4, 1'b0, 1'b0, "npulse0");
        run_train(3, 0, 0, 1'b0, 1'b0, "zero_len");
        run_train(4, 5, 5, 1'b1, 1'b0, "disturb");
        run_train(1, 255, 3, 1'b0, 1'b0, "max_high");
        run_train(2, 1, 255, 1'b0, 1'b0, "max_low");
        run_train(255, 0, 0, 1'b0, 1'b0, "max_npulse");
        for (int t = 0; t < 10; t++) run_train(1, 2, 1, 1'b0, t != 9, "held_start");
        for (int t = 0; t < 20; t++)
            run_train($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                       1'($urandom_range(0, 1)), 1'b0, "random");
        // abort during the second high phase of a 5-pulse train, between clock edges
        START = 1'b1;
        NPULSE = 8'd5;
        HIGH_CYC = 8'd3;
        LOW_CYC = 8'd2;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("abort.pre_dout", {7'd0, DOUT}, 8'd1);
        chk("abort.pre_pcount", PCOUNT, 8'd1);
        #1 RST = 1'b1;
        #1;
        chk("abort.dout", {7'd0, DOUT}, 8'd0);
        chk("abort.busy", {7'd0, BUSY}, 8'd0);
        chk("abort.pcount", PCOUNT, 8'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("abort.done", {7'd0, DONE}, 8'd0);
        end
        RST = 1'b0;
        @(negedge CLK);
        chk("abort.after_done", {7'd0, DONE}, 8'd0);
        chk("abort.after_busy", {7'd0, BUSY}, 8'd0);
        run_train(1, 3, 2, 1'b0, 1'b0, "after_abort");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
